// File: rtl/mul_sequencer_if.sv
// Signal bundle between decode/execute and the MUL sequencer.
// The sequencer sits on the slave side; decode/execute and the ALU sit on the master side.
interface mul_sequencer_if #(
    parameter int WORD = 64
);
    logic            start;
    logic [WORD-1:0] op_a;
    logic [WORD-1:0] op_b;
    logic [WORD-1:0] alu_a_in;
    logic [WORD-1:0] alu_b_in;
    logic [3:0]      alu_op_in;
    logic            update_sreg_in;
    logic [WORD-1:0] alu_result;
    logic [WORD-1:0] alu_a_out;
    logic [WORD-1:0] alu_b_out;
    logic [3:0]      alu_op_out;
    logic            update_sreg_out;
    logic [WORD-1:0] result;
    logic            stall;
    logic            busy;
    logic            done;

    modport slave (
        input  start, op_a, op_b, alu_a_in, alu_b_in, alu_op_in, update_sreg_in, alu_result,
        output alu_a_out, alu_b_out, alu_op_out, update_sreg_out, result, stall, busy, done
    );

    modport master (
        output start, op_a, op_b, alu_a_in, alu_b_in, alu_op_in, update_sreg_in, alu_result,
        input  alu_a_out, alu_b_out, alu_op_out, update_sreg_out, result, stall, busy, done
    );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-and-add MUL controller that borrows the shared main ALU for one add per cycle.
// Idle: ALU path is a straight pass-through; MUL: stalls the datapath until the product is ready.
module mul_sequencer #(
    parameter int          WORD    = 64,
    parameter logic [3:0]  ALU_ADD = 4'b0010
) (
    input  logic               clk,
    input  logic               reset,
    mul_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [WORD-1:0] acc_reg, acc_next;
    logic [WORD-1:0] mcand_reg, mcand_next;
    logic [WORD-1:0] mplier_reg, mplier_next;
    logic [WORD-1:0] mplier_shifted;

    logic [WORD-1:0] alu_a_out;
    logic [WORD-1:0] alu_b_out;
    logic [3:0]      alu_op_out;
    logic            update_sreg_out;
    logic [WORD-1:0] result;
    logic            stall;
    logic            done;

    assign mplier_shifted = mplier_reg >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        mcand_next      = mcand_reg;
        mplier_next     = mplier_reg;
        alu_a_out       = bus.alu_a_in;
        alu_b_out       = bus.alu_b_in;
        alu_op_out      = bus.alu_op_in;
        update_sreg_out = bus.update_sreg_in;
        result          = bus.alu_result;
        stall           = 1'b0;
        done            = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    // MUL never touches NZCV, even in its issue cycle.
                    update_sreg_out = 1'b0;
                    stall           = 1'b1;
                    acc_next        = '0;
                    mcand_next      = bus.op_a;
                    mplier_next     = bus.op_b;
                    state_next      = (bus.op_b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                alu_a_out       = acc_reg;
                alu_b_out       = mcand_reg;
                alu_op_out      = ALU_ADD;
                update_sreg_out = 1'b0;
                stall           = 1'b1;
                if (mplier_reg[0]) begin
                    acc_next = bus.alu_result;
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_shifted;
                // Stop as soon as no set multiplier bits remain.
                if (mplier_shifted == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                update_sreg_out = 1'b0;
                result          = acc_reg;
                done            = 1'b1;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.alu_a_out       = alu_a_out;
    assign bus.alu_b_out       = alu_b_out;
    assign bus.alu_op_out      = alu_op_out;
    assign bus.update_sreg_out = update_sreg_out;
    assign bus.result          = result;
    assign bus.stall           = stall;
    assign bus.busy            = (state_reg != IDLE);
    assign bus.done            = done;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: pass-through, MUL latency/product, reset abort, back-to-back.
module tb_mul_sequencer;
    localparam int         WORD    = 64;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_sequencer_if #(.WORD(WORD)) bus ();

    mul_sequencer #(.WORD(WORD), .ALU_ADD(ALU_ADD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment model of the main ALU.
    always_comb begin
        case (bus.alu_op_out)
            ALU_ADD: bus.alu_result = bus.alu_a_out + bus.alu_b_out;
            ALU_SUB: bus.alu_result = bus.alu_a_out - bus.alu_b_out;
            default: bus.alu_result = bus.alu_a_out & bus.alu_b_out;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mul_run(input logic [63:0] a, input logic [63:0] b, input logic [63:0] prod,
                           input int n, input bit spurious);
        int cycles;
        int stall_cnt;
        bit upd_seen;
        bit got_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        #1;
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_done", 64'(bus.done), 64'd0);
        check("start_stall", 64'(bus.stall), 64'd1);
        check("start_upd", 64'(bus.update_sreg_out), 64'd0);
        stall_cnt = 1;
        upd_seen  = 1'b0;
        got_done  = 1'b0;
        cycles    = 0;
        while (!got_done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (spurious) begin
                bus.op_a = ~a;
                bus.op_b = 64'h3;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            if (bus.stall) stall_cnt++;
            if (bus.update_sreg_out) upd_seen = 1'b1;
            if (cycles == 1 && n > 0) begin
                check("run_op", 64'(bus.alu_op_out), 64'(ALU_ADD));
                check("run_a_acc0", bus.alu_a_out, 64'd0);
                check("run_b_mcand", bus.alu_b_out, a);
            end
            if (bus.done) got_done = 1'b1;
        end
        check("done_seen", 64'(got_done), 64'd1);
        check("done_cycle", 64'(cycles), 64'(n + 1));
        check("result", bus.result, prod);
        check("done_stall", 64'(bus.stall), 64'd0);
        check("done_busy", 64'(bus.busy), 64'd1);
        check("done_pass_a", bus.alu_a_out, 64'd5);
        check("stall_cycles", 64'(stall_cnt), 64'(n + 1));
        check("upd_never", 64'(upd_seen), 64'd0);
        $display("MUL %h x %h -> %h in %0d cycles", a, b, bus.result, cycles);
        bus.start = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.op_a           = '0;
        bus.op_b           = '0;
        bus.alu_a_in       = 64'd5;
        bus.alu_b_in       = 64'd3;
        bus.alu_op_in      = ALU_SUB;
        bus.update_sreg_in = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_pass_a", bus.alu_a_out, 64'd5);
        reset = 1'b0;

        @(negedge clk);
        #1;
        check("pt_a", bus.alu_a_out, 64'd5);
        check("pt_b", bus.alu_b_out, 64'd3);
        check("pt_op", 64'(bus.alu_op_out), 64'(ALU_SUB));
        check("pt_upd", 64'(bus.update_sreg_out), 64'd1);
        check("pt_result", bus.result, 64'd2);
        check("pt_stall", 64'(bus.stall), 64'd0);
        check("pt_busy", 64'(bus.busy), 64'd0);
        $display("PASSTHRU a=5 b=3 op=0110 -> result %h", bus.result);

        mul_run(64'd7, 64'd6, 64'd42, 3, 1'b0);
        mul_run(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 0, 1'b0);
        mul_run(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 64, 1'b0);

        // Abort a long MUL at its third iteration.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 64'd9;
        bus.op_b  = 64'hFF;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_stall", 64'(bus.stall), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_done", 64'(bus.done), 64'd0);
        end
        $display("RESET mid-MUL 9 x ff aborted");
        mul_run(64'd3, 64'd4, 64'd12, 3, 1'b0);

        mul_run(64'd2, 64'd3, 64'd6, 2, 1'b1);
        mul_run(64'd5, 64'd5, 64'd25, 3, 1'b0);

        @(negedge clk);
        #1;
        check("final_done", 64'(bus.done), 64'd0);
        check("final_busy", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
